// File: rtl/alu_loader_pkg.sv
// Shared types and constants for the ALU operand loader.
// Header byte layout, FSM states and error cause codes.
package alu_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_A,
    GET_B,
    ISSUE
  } state_t;

  localparam int MARK_BIT  = 7;
  localparam int UNARY_BIT = 6;
  localparam int OPC_W     = 4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_OVR  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/alu_operand_loader_stb_sync.sv
// Strobe synchronizer chain plus rising-edge detector.
// Emits a one-cycle byte_pulse per synchronized rise of in_stb.
module stb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_stb,
  output logic byte_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_stb};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign byte_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Byte-stream command assembler feeding the ALU core.
// Optional GET_A/GET_B inactivity timeout: LOADER_TIMEOUT_EN.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       in_data,
  input  logic             in_stb,
  input  logic             clr_err,
  input  logic             op_ready,
  output logic             op_valid,
  output logic [OPC_W-1:0] op_code,
  output logic [7:0]       op_a,
  output logic [7:0]       op_b,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       op_count
);

  logic byte_pulse;

  stb_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_stb_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_stb    (in_stb),
    .byte_pulse(byte_pulse)
  );

  state_t           state_q, state_d;
  logic             unary_q, unary_d;
  logic [OPC_W-1:0] op_code_d;
  logic [7:0]       op_a_d, op_b_d;
  logic             op_valid_d;
  logic [7:0]       op_count_d;
  logic             err_d;
  logic [1:0]       err_code_d;
  logic [1:0]       new_err;
  logic             tmo_hit;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          in_get;

  assign in_get  = (state_q == GET_A) || (state_q == GET_B);
  assign tmo_hit = in_get && !byte_pulse && (tmo_q == TMO_LAST);

  // Held at zero outside GET_A/GET_B, so entering GET_A starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (ena) begin
      if (byte_pulse || !in_get) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = TIMEOUT_CYCLES < 0;
`endif

  always_comb begin
    state_d    = state_q;
    unary_d    = unary_q;
    op_code_d  = op_code;
    op_a_d     = op_a;
    op_b_d     = op_b;
    op_valid_d = op_valid;
    op_count_d = op_count;
    new_err    = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        if (byte_pulse) begin
          if (!in_data[MARK_BIT]) begin
            new_err = ERR_HDR;
          end else begin
            op_code_d = in_data[OPC_W-1:0];
            unary_d   = in_data[UNARY_BIT];
            state_d   = GET_A;
          end
        end
      end
      GET_A: begin
        if (byte_pulse) begin
          op_a_d = in_data;
          if (unary_q) begin
            op_b_d     = 8'h00;
            op_valid_d = 1'b1;
            state_d    = ISSUE;
          end else begin
            state_d = GET_B;
          end
        end else if (tmo_hit) begin
          new_err = ERR_TMO;
          state_d = IDLE;
        end
      end
      GET_B: begin
        if (byte_pulse) begin
          op_b_d     = in_data;
          op_valid_d = 1'b1;
          state_d    = ISSUE;
        end else if (tmo_hit) begin
          new_err = ERR_TMO;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (byte_pulse) new_err = ERR_OVR;
        if (op_valid && op_ready) begin
          op_valid_d = 1'b0;
          op_count_d = op_count + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // First error since the last clear wins; a coincident new error beats clr_err.
    err_d      = err;
    err_code_d = err_code;
    if (new_err != ERR_NONE && (!err || clr_err)) begin
      err_d      = 1'b1;
      err_code_d = new_err;
    end else if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      unary_q  <= 1'b0;
      op_code  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      op_count <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (ena) begin
      state_q  <= state_d;
      unary_q  <= unary_d;
      op_code  <= op_code_d;
      op_a     <= op_a_d;
      op_b     <= op_b_d;
      op_valid <= op_valid_d;
      op_count <= op_count_d;
      busy     <= (state_d != IDLE);
      err      <= err_d;
      err_code <= err_code_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: commands are modelled as
// whole byte sequences and matched against every accepted handshake.
module tb_alu_operand_loader;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_stb = 1'b0;
  logic       clr_err = 1'b0;
  logic       op_ready = 1'b0;
  logic       op_valid;
  logic [3:0] op_code;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] op_count;

  alu_operand_loader #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .in_data (in_data),
    .in_stb  (in_stb),
    .clr_err (clr_err),
    .op_ready(op_ready),
    .op_valid(op_valid),
    .op_code (op_code),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .err     (err),
    .err_code(err_code),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  int   ready_mode = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       op_ready = 1'b0;
        1:       op_ready = 1'b1;
        default: op_ready = 1'($urandom_range(1, 0));
      endcase
    end
  endtask

  task automatic monitor();
    cmd_t prev;
    cmd_t got;
    cmd_t e;
    logic pv;
    pv = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_cnt = 0;
        pv = 1'b0;
        continue;
      end
      got = {op_code, op_a, op_b};
      if (pv && op_valid) chk("stable", got, prev);
      if (op_valid && op_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd: got %0h expected none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL cmd: got %0h expected %0h", got, e);
          end
        end
        chk("op_count", op_count, exp_cnt % 256);
        exp_cnt++;
        pv = 1'b0;
      end else begin
        pv = op_valid;
        prev = got;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    in_data = b;
    in_stb = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    in_stb = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Reference: a header with the marker set plus its operands yields one
  // command; unary commands carry operand B as zero.
  task automatic send_cmd(input logic [7:0] h, input logic [7:0] a,
                          input logic [7:0] b);
    cmd_t e;
    e.c = h[3:0];
    e.a = a;
    e.b = h[6] ? 8'h00 : b;
    sb.push_back(e);
    send_byte(h);
    send_byte(a);
    if (!h[6]) send_byte(b);
  endtask

  task automatic drain();
    int n;
    ready_mode = 1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  initial begin
    fork
      ready_drv();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_ops", {op_code, op_a, op_b, op_count}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 256 back-to-back unary commands wrap op_count to zero.
    ready_mode = 1;
    for (int i = 0; i < 256; i++)
      send_cmd(8'hC0 | 8'(i % 16), 8'(i), 8'h00);
    drain();
    chk("wrap", op_count, 0);

    send_cmd(8'h83, 8'h25, 8'h11);
    drain();
    chk("bin_count", op_count, 1);
    chk("bin_busy", busy, 0);

    ready_mode = 0;
    send_cmd(8'hC7, 8'hF0, 8'h00);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", op_valid, 1);
    end
    chk("stall_ops", {op_code, op_a, op_b}, 20'h7F000);
    ready_mode = 1;
    @(negedge clk);
    chk("drop_pre", op_valid, 1);
    @(negedge clk);
    chk("drop_post", op_valid, 0);

    send_byte(8'h05);
    @(negedge clk);
    chk("hdr_err", {err, err_code}, 3'b101);
    chk("hdr_busy", busy, 0);

    ready_mode = 0;
    send_cmd(8'h83, 8'h25, 8'h11);
    send_byte(8'h44);
    @(negedge clk);
    chk("first_err_kept", {err, err_code}, 3'b101);
    pulse_clr();
    @(negedge clk);
    chk("clr", {err, err_code}, 0);
    send_byte(8'h99);
    @(negedge clk);
    chk("ovr_err", {err, err_code}, 3'b110);
    chk("ovr_ops", {op_valid, op_code, op_a, op_b}, 21'h132511);
    drain();
    pulse_clr();

    @(negedge clk);
    ena = 1'b0;
    send_byte(8'h83);
    send_byte(8'h05);
    @(negedge clk);
    chk("ena_busy", busy, 0);
    chk("ena_err", err, 0);
    ena = 1'b1;

    send_byte(8'h81);
    repeat (TMO + 4) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    chk("tmo_busy", busy, 0);
    chk("tmo_err", {err, err_code}, 3'b111);
    pulse_clr();
`else
    chk("notmo_busy", busy, 1);
    chk("notmo_err", err, 0);
    sb.push_back({4'h1, 8'h5A, 8'hA5});
    send_byte(8'h5A);
    send_byte(8'hA5);
    drain();
`endif

    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] h;
      h = 8'($urandom_range(255, 0)) | 8'h80;
      send_cmd(h, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
    drain();
    @(negedge clk);
    chk("rand_err", err, 0);

    send_byte(8'h82);
    send_byte(8'h10);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {op_valid, busy, err, err_code}, 0);
    chk("mid_rst_ops", {op_code, op_a, op_b, op_count}, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_cmd(8'h82, 8'h01, 8'h02);
    drain();
    chk("post_rst_count", op_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the ALU user project.
- Assembles an ALU command from a byte stream presented on the 8-bit dedicated input pins, qualified by an asynchronous external strobe.
- Issues each command as one opcode/operand bundle to the ALU core over a valid/ready handshake.
- Reports status: busy, sticky error, and a completed-command count.

Parameters:
- SYNC_STAGES, 2, flops in the strobe synchronizer chain; minimum 2.
- TIMEOUT_CYCLES, 1023, idle clocks allowed between bytes of one command. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ena  in  1  design enable; low freezes the FSM
- in_data  in  8  byte bus from ui_in
- in_stb  in  1  asynchronous byte strobe from a uio_in pin; a rising edge marks a byte
- clr_err  in  1  synchronous clear of err and err_code
- op_ready  in  1  ALU core accepts the command
- op_valid  out  1  command bundle valid
- op_code  out  4  ALU opcode
- op_a  out  8  operand A
- op_b  out  8  operand B; 0 for unary commands
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky error flag
- err_code  out  2  first error cause: 0 none, 1 bad header, 2 overrun, 3 timeout
- op_count  out  8  commands accepted by the ALU, mod 256

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; synchronizer flops 0.
- Strobe path:
  - in_stb passes through SYNC_STAGES flops plus one edge-history flop.
  - byte_pulse = synced & ~history.
  - A pin rise before clk edge k gives byte_pulse high in the cycle ending at edge k+SYNC_STAGES. in_data is captured at that edge.
  - The external driver holds in_data stable for at least SYNC_STAGES+2 clocks after raising in_stb.
- ena low: the synchronizer keeps running; byte_pulse is ignored; FSM, outputs and counters hold.
- Header byte format:
  - bit7 = 1 marker.
  - bit6 = unary flag.
  - bits5:4 are reserved and ignored.
  - bits3:0 = opcode.
- FSM states: IDLE, GET_A, GET_B, ISSUE.
- IDLE, on byte_pulse:
  - bit7 = 0: discard the byte, set err with code 1, stay IDLE.
  - Otherwise: latch op_code, then go to GET_A.
- GET_A, on byte_pulse: latch op_a.
  - Unary flag set: op_b := 0, go to ISSUE.
  - Unary flag clear: go to GET_B.
- GET_B, on byte_pulse: latch op_b, go to ISSUE.
- ISSUE:
  - op_valid is high, registered, asserted the cycle after entering ISSUE.
  - op_code, op_a and op_b stay stable while op_valid is high.
  - When op_valid & op_ready at a clk edge: op_valid drops next cycle, op_count increments (wrapping 255 -> 0), state returns to IDLE.
  - A byte_pulse arriving in ISSUE is dropped, sets err with code 2, and does not disturb the pending command.
- busy = (state != IDLE), registered with the state.
- err/err_code:
  - Only the first error since the last clear is recorded.
  - Later errors leave err_code unchanged.
  - clr_err clears both next cycle.
  - clr_err and a new error in the same cycle: the new error wins.
- Byte_pulse coincident with op_ready in ISSUE: the handshake completes, the byte is dropped and flagged as overrun.
- rst_n asserted mid-command aborts it immediately. Any partially latched operands are lost; op_valid drops asynchronously.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) resets on each byte_pulse and on entering GET_A.
  - It counts while in GET_A or GET_B with ena high.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE and sets err with code 3, so a half-received command is abandoned.
  - ISSUE is never timed out.
- Undefined: no counter exists; GET_A/GET_B wait indefinitely; err_code 3 is never produced.

Decomposition:
- Package alu_loader_pkg holds:
  - the state enum;
  - header bit positions (MARK_BIT=7, UNARY_BIT=6);
  - OPC_W=4;
  - the err_code constants (ERR_NONE, ERR_HDR, ERR_OVR, ERR_TMO).
- Sub-module stb_sync: SYNC_STAGES synchronizer plus rising-edge detector; outputs byte_pulse.

Test Plan:
- Binary command: bytes 0x83, 0x25, 0x11 with op_ready held 1 -> single op_valid pulse with op_code=3, op_a=0x25, op_b=0x11; op_count 0 -> 1; busy back to 0.
- Unary command with stall: bytes 0xC7, 0xF0, op_ready held 0 for 5 cycles -> op_valid stays high with op_code=7, op_a=0xF0, op_b=0x00 stable; it drops one cycle after op_ready rises.
- Bad header plus overrun: byte 0x05 -> err=1, err_code=1, state IDLE. Then clr_err; then a command stalled in ISSUE plus an extra strobe -> err_code=2, and the pending operands are unchanged.
- ena gating and count wrap: strobes with ena=0 -> no state change. Then 256 back-to-back commands -> op_count wraps to 0.
- Timeout, LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16: byte 0x81, then silence -> after 16 clocks state is IDLE and err_code=3. Without the macro, the FSM stays in GET_A.
- Reset mid-command: after 0x82 and 0x10, pulse rst_n low -> all outputs 0. A following 0x82, 0x01, 0x02 issues op_a=0x01 and op_b=0x02.
